forwarding_scoreboard: RTL and testbench

FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

---
 rtl/forwarding_scoreboard_pkg.sv | 18 +
 rtl/forwarding_scoreboard_fwd_match_prio.sv | 47 ++++
 rtl/forwarding_scoreboard.sv | 122 ++++++++++++
 tb/tb_forwarding_scoreboard.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/forwarding_scoreboard_pkg.sv
// Shared types and select codes for the forwarding scoreboard.
// Tag rd fields are zero-extended to TagRdW, so REG_ADDR_W must not exceed TagRdW.
package forwarding_scoreboard_pkg;

  localparam int unsigned TagRdW = 8;
  localparam int unsigned TagW   = TagRdW + 2;

  // Wide constants; users truncate them to their own select width.
  localparam logic [7:0] SEL_RF     = 8'h00;
  localparam logic [7:0] SEL_PC_IMM = 8'hFF;

  typedef struct packed {
    logic              valid;
    logic              is_load;
    logic [TagRdW-1:0] rd;
  } fwd_tag_t;

endpackage

// File: rtl/forwarding_scoreboard_fwd_match_prio.sv
// Priority match of one decode source against the downstream stage tags; the
// nearest (lowest-index) matching stage wins the select code.
module fwd_match_prio
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned REG_ADDR_W = 5,
  localparam int unsigned SEL_W     = $clog2(FWD_STAGES + 2)
) (
  input  logic [FWD_STAGES-1:0]        valid_i,
  input  logic [FWD_STAGES*TagRdW-1:0] rd_i,
  input  logic                         load0_i,
  input  logic [REG_ADDR_W-1:0]        src_i,
  input  logic                         use_i,
  input  logic                         override_i,
  output logic [SEL_W-1:0]             sel_o,
  output logic                         any_hit_o,
  output logic                         load_hit_o
);

  logic [TagRdW-1:0]     src_ext;
  logic [FWD_STAGES-1:0] hit;
  logic                  found;

  assign src_ext = TagRdW'(src_i);

  // Register 0 never matches, so rd=0 tags are inert.
  for (genvar g = 0; g < FWD_STAGES; g++) begin : g_hit
    assign hit[g] = valid_i[g] && (rd_i[g*TagRdW +: TagRdW] == src_ext) && (src_ext != '0);
  end

  always_comb begin
    sel_o = SEL_RF[SEL_W-1:0];
    found = 1'b0;
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      if (hit[k] && !found) begin
        sel_o = SEL_W'(FWD_STAGES - k);
        found = 1'b1;
      end
    end
    if (override_i) sel_o = SEL_PC_IMM[SEL_W-1:0];
  end

  assign any_hit_o  = use_i && !override_i && (|hit);
  assign load_hit_o = use_i && !override_i && hit[0] && load0_i;

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand-forwarding scoreboard: tracks rd tags of downstream stages, selects
// operand sources and detects hazards. GR5_FORWARDING_EN enables forwarding;
// without it every hazard against an in-flight write stalls decode.
module forwarding_scoreboard
  import forwarding_scoreboard_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned REG_ADDR_W = 5,
  localparam int unsigned SEL_W     = $clog2(FWD_STAGES + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_pc_operation,
  input  logic                  id_immediate,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  advance,
  input  logic                  flush,
  output logic [SEL_W-1:0]      op_rs1,
  output logic [SEL_W-1:0]      op_rs2,
  output logic                  stall,
  output logic [31:0]           stall_count
);

  fwd_tag_t [FWD_STAGES-1:0] tags_q, tags_d;
  logic [31:0]               stall_count_q, stall_count_d;

  logic [FWD_STAGES-1:0]        tag_valid;
  logic [FWD_STAGES*TagRdW-1:0] tag_rd;

  for (genvar g = 0; g < FWD_STAGES; g++) begin : g_flat
    assign tag_valid[g]                 = tags_q[g].valid;
    assign tag_rd[g*TagRdW +: TagRdW]   = tags_q[g].rd;
  end

  logic [SEL_W-1:0] sel_rs1, sel_rs2;
  logic             any_hit_rs1, any_hit_rs2, load_hit_rs1, load_hit_rs2;

  fwd_match_prio #(
    .FWD_STAGES (FWD_STAGES),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_match_rs1 (
    .valid_i    (tag_valid),
    .rd_i       (tag_rd),
    .load0_i    (tags_q[0].is_load),
    .src_i      (id_rs1),
    .use_i      (id_use_rs1),
    .override_i (id_pc_operation),
    .sel_o      (sel_rs1),
    .any_hit_o  (any_hit_rs1),
    .load_hit_o (load_hit_rs1)
  );

  fwd_match_prio #(
    .FWD_STAGES (FWD_STAGES),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_match_rs2 (
    .valid_i    (tag_valid),
    .rd_i       (tag_rd),
    .load0_i    (tags_q[0].is_load),
    .src_i      (id_rs2),
    .use_i      (id_use_rs2),
    .override_i (id_immediate),
    .sel_o      (sel_rs2),
    .any_hit_o  (any_hit_rs2),
    .load_hit_o (load_hit_rs2)
  );

`ifdef GR5_FORWARDING_EN
  // Only a load one stage ahead cannot be forwarded in time.
  assign op_rs1 = sel_rs1;
  assign op_rs2 = sel_rs2;
  assign stall  = id_valid && (load_hit_rs1 || load_hit_rs2);

  logic unused_any_hit;
  assign unused_any_hit = any_hit_rs1 ^ any_hit_rs2;
`else
  assign op_rs1 = id_pc_operation ? SEL_PC_IMM[SEL_W-1:0] : SEL_RF[SEL_W-1:0];
  assign op_rs2 = id_immediate    ? SEL_PC_IMM[SEL_W-1:0] : SEL_RF[SEL_W-1:0];
  assign stall  = id_valid && (any_hit_rs1 || any_hit_rs2);

  logic unused_fwd;
  assign unused_fwd = ^{sel_rs1, sel_rs2, load_hit_rs1, load_hit_rs2};
`endif

  logic unused_last_load;
  assign unused_last_load = tags_q[FWD_STAGES-1].is_load;

  always_comb begin
    tags_d        = tags_q;
    stall_count_d = stall_count_q;
    if (advance) begin
      for (int unsigned k = 1; k < FWD_STAGES; k++) tags_d[k] = tags_q[k-1];
      tags_d[0].valid   = id_valid && id_reg_write && (id_rd != '0) && !stall && !flush;
      tags_d[0].is_load = id_is_load;
      tags_d[0].rd      = TagRdW'(id_rd);
    end
    if (flush) tags_d[0].valid = 1'b0;
    if (stall && advance && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tags_q        <= '0;
      stall_count_q <= '0;
    end else begin
      tags_q        <= tags_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Self-checking bench: FWD_STAGES=2 and FWD_STAGES=4 instances share stimulus and
// are compared against an array-based reference model each cycle.
module tb_forwarding_scoreboard;

`ifdef GR5_FORWARDING_EN
  localparam bit FwdMode = 1'b1;
`else
  localparam bit FwdMode = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_pc_operation, id_immediate;
  logic       id_valid, id_reg_write, id_is_load, advance, flush;

  logic [1:0]  op_rs1_a, op_rs2_a;
  logic [2:0]  op_rs1_b, op_rs2_b;
  logic        stall_a, stall_b;
  logic [31:0] cnt_a, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  forwarding_scoreboard #(.FWD_STAGES(2), .REG_ADDR_W(5)) u_dut_a (
    .clk (clk), .rst (rst), .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .id_pc_operation (id_pc_operation), .id_immediate (id_immediate),
    .id_valid (id_valid), .id_reg_write (id_reg_write), .id_is_load (id_is_load),
    .id_rd (id_rd), .advance (advance), .flush (flush),
    .op_rs1 (op_rs1_a), .op_rs2 (op_rs2_a), .stall (stall_a), .stall_count (cnt_a)
  );

  forwarding_scoreboard #(.FWD_STAGES(4), .REG_ADDR_W(5)) u_dut_b (
    .clk (clk), .rst (rst), .id_rs1 (id_rs1), .id_rs2 (id_rs2),
    .id_use_rs1 (id_use_rs1), .id_use_rs2 (id_use_rs2),
    .id_pc_operation (id_pc_operation), .id_immediate (id_immediate),
    .id_valid (id_valid), .id_reg_write (id_reg_write), .id_is_load (id_is_load),
    .id_rd (id_rd), .advance (advance), .flush (flush),
    .op_rs1 (op_rs1_b), .op_rs2 (op_rs2_b), .stall (stall_b), .stall_count (cnt_b)
  );

  // Reference model: index 0 -> 2-stage instance, index 1 -> 4-stage instance.
  bit     mv [2][6];
  int     mrd [2][6];
  bit     ml [2][6];
  longint mcnt [2];

  function automatic int n_of(int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int exp_sel(int i, int src, bit ovr);
    int n   = n_of(i);
    int hit = 0;
    for (int k = n - 1; k >= 0; k--)
      if (mv[i][k] && mrd[i][k] == src && src != 0) hit = n - k;
    if (ovr) return (i == 0) ? 3 : 7;
    if (FwdMode) return hit;
    return 0;
  endfunction

  function automatic bit exp_stall(int i);
    bit any = 1'b0;
    bit ld  = 1'b0;
    for (int k = 0; k < n_of(i); k++) begin
      if (mv[i][k] && mrd[i][k] != 0 &&
          ((id_use_rs1 && !id_pc_operation && mrd[i][k] == int'(id_rs1)) ||
           (id_use_rs2 && !id_immediate && mrd[i][k] == int'(id_rs2)))) begin
        any = 1'b1;
        if (k == 0 && ml[i][0]) ld = 1'b1;
      end
    end
    if (!id_valid) return 1'b0;
    return FwdMode ? ld : any;
  endfunction

  task automatic model_step(int i, bit st);
    if (rst) begin
      for (int k = 0; k < 6; k++) mv[i][k] = 1'b0;
      mcnt[i] = 0;
    end else begin
      if (advance && st && mcnt[i] != 64'hFFFF_FFFF) mcnt[i]++;
      if (advance) begin
        for (int k = n_of(i) - 1; k >= 1; k--) begin
          mv[i][k]  = mv[i][k-1];
          mrd[i][k] = mrd[i][k-1];
          ml[i][k]  = ml[i][k-1];
        end
        mv[i][0]  = id_valid && id_reg_write && id_rd != 0 && !st && !flush;
        mrd[i][0] = int'(id_rd);
        ml[i][0]  = id_is_load;
      end
      if (flush) mv[i][0] = 1'b0;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after an edge; outputs are sampled mid-cycle.
  task automatic cycle();
    bit st_a, st_b;
    #2;
    st_a = exp_stall(0);
    st_b = exp_stall(1);
    check("A.op_rs1", 32'(op_rs1_a), exp_sel(0, id_rs1, id_pc_operation));
    check("A.op_rs2", 32'(op_rs2_a), exp_sel(0, id_rs2, id_immediate));
    check("A.stall", 32'(stall_a), 32'(st_a));
    check("A.stall_count", cnt_a, 32'(mcnt[0]));
    check("B.op_rs1", 32'(op_rs1_b), exp_sel(1, id_rs1, id_pc_operation));
    check("B.op_rs2", 32'(op_rs2_b), exp_sel(1, id_rs2, id_immediate));
    check("B.stall", 32'(stall_b), 32'(st_b));
    check("B.stall_count", cnt_b, 32'(mcnt[1]));
    model_step(0, st_a);
    model_step(1, st_b);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, bit rw, bit ld, logic [4:0] rd, logic [4:0] rs1, bit u1,
                       logic [4:0] rs2, bit u2, bit pc, bit imm, bit adv, bit fl);
    id_valid = v;    id_reg_write = rw; id_is_load = ld; id_rd = rd;
    id_rs1 = rs1;    id_use_rs1 = u1;   id_rs2 = rs2;    id_use_rs2 = u2;
    id_pc_operation = pc; id_immediate = imm; advance = adv; flush = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    cycle();                                   // reset state
    rst = 1'b0;

    // Same rd in two stages: nearest wins.
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0); cycle();

    // rd=7 only in stage 1; immediate overrides rs2.
    drive(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0); cycle();

    // Load-use: one stall, then forward from stage 1.
    drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 0); cycle();
    cycle();
    cycle();

    // Flush without advance kills stage 0 only.
    drive(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(1, 1, 0, 6, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(1, 1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    drive(1, 0, 0, 0, 6, 1, 4, 1, 0, 0, 0, 0); cycle();

    // Reset in the middle of a shift with everything valid.
    for (int r = 10; r < 14; r++) begin
      drive(1, 1, 0, 5'(r), 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    end
    rst = 1'b1;
    drive(1, 1, 1, 14, 0, 0, 0, 0, 0, 0, 1, 1); cycle();
    rst = 1'b0;
    drive(1, 0, 0, 0, 12, 1, 13, 1, 0, 0, 0, 0); cycle();

    // rd=9 travels to the last stage of the 4-stage instance.
    drive(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle(); cycle(); cycle();
    drive(1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0); cycle();

    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom), bit'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), bit'($urandom),
            5'($urandom_range(0, 7)), bit'($urandom),
            bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 5) == 0),
            bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
